// File: rtl/writeback_buffer.sv
// Write-back buffer: an in-order queue of register-file writes drained one per
// cycle into a registered write port, with a combinational forwarding lookup
// that returns the youngest pending value for a queried register.
module writeback_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [4:0]                 in_reg,
   input  logic [31:0]                in_data,
   input  logic                       hold,
   output logic [4:0]                 write_reg,
   output logic [31:0]                write_data,
   output logic                       write_en,
   input  logic [4:0]                 pend_query,
   output logic                       pend_hit,
   output logic [31:0]                pend_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Queue storage carries no reset; occupancy is tracked by count_q alone.
   logic [4:0]    reg_mem  [DEPTH];
   logic [31:0]   data_mem [DEPTH];

   logic [AW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q, count_d;
   logic [4:0]    wreg_q;
   logic [31:0]   wdata_q;
   logic          wen_q;

   logic          push, pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign in_ready = !full;
   assign count    = count_q;

   assign write_reg  = wreg_q;
   assign write_data = wdata_q;
   assign write_en   = wen_q;

   // Writes to r0 are accepted but dropped; a pop never frees a slot for a
   // same-cycle push because in_ready is derived from the current count only.
   assign push = in_valid && in_ready && (in_reg != 5'd0);
   assign pop  = !empty && !hold;

   // Occupancy bookkeeping for simultaneous push/pop.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers, occupancy and the registered register-file write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         wen_q   <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
      end else begin
         count_q <= count_d;
         wen_q   <= pop;
         if (push) tail_q <= tail_q + AW'(1);
         if (pop) begin
            head_q  <= head_q + AW'(1);
            wreg_q  <= reg_mem[head_q];
            wdata_q <= data_mem[head_q];
         end
      end
   end

   // Entry storage written at the tail on every enqueue.
   always_ff @(posedge clk) begin
      if (push) begin
         reg_mem[tail_q]  <= in_reg;
         data_mem[tail_q] <= in_data;
      end
   end

   // Forwarding: scan output register first, then queue oldest to youngest so
   // the last match found is the youngest pending value.
   always_comb begin
      logic [AW-1:0] idx;
      pend_hit  = 1'b0;
      pend_data = '0;
      idx       = '0;
      if (pend_query != 5'd0) begin
         if (wen_q && (wreg_q == pend_query)) begin
            pend_hit  = 1'b1;
            pend_data = wdata_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if ((CW'(i) < count_q) && (reg_mem[idx] == pend_query)) begin
               pend_hit  = 1'b1;
               pend_data = data_mem[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench for writeback_buffer: a scoreboard queue holds expected
// register-file writes; a monitor pops and compares them whenever write_en is
// seen, and each scenario task makes its own direct checks as well.
module tb_writeback_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_reg;
   logic [31:0] in_data;
   logic        hold;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        write_en;
   logic [4:0]  pend_query;
   logic        pend_hit;
   logic [31:0] pend_data;
   logic [$clog2(DEPTH):0] count;
   logic        full;
   logic        empty;

   int n_cmp = 0;
   int n_err = 0;
   logic [36:0] exp_q[$];

   writeback_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_reg(in_reg), .in_data(in_data), .hold(hold),
      .write_reg(write_reg), .write_data(write_data), .write_en(write_en),
      .pend_query(pend_query), .pend_hit(pend_hit), .pend_data(pend_data),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every write must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && write_en) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected_write: got reg=%0d data=%h, expected no write", write_reg, write_data);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({write_reg, write_data} !== e) begin
               n_err++;
               $display("FAIL sb_write: got reg=%0d data=%h, expected reg=%0d data=%h",
                        write_reg, write_data, e[36:32], e[31:0]);
            end
         end
      end
   end

   // Drive one request for one cycle; the scoreboard learns of it only if accepted.
   task automatic push(input logic [4:0] r, input logic [31:0] d, output logic acc);
      @(negedge clk);
      in_valid = 1'b1;
      in_reg   = r;
      in_data  = d;
      acc      = in_ready;
      if (acc && r != 5'd0) exp_q.push_back({r, d});
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_reg   = '0;
      in_data  = '0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && empty && !write_en) && n < 50) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (n >= 50) begin
         n_err++;
         $display("FAIL %s_drain_timeout: %0d writes still expected, empty=%b", name, exp_q.size(), empty);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0; hold = 1'b0; pend_query = 5'd3;
      #1;
      n_cmp++;
      if ({write_en, write_reg, write_data, count, empty, full, in_ready, pend_hit} !==
          {1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL reset_state: got en=%b reg=%0d data=%h cnt=%0d e=%b f=%b rdy=%b hit=%b, expected 0 0 0 0 1 0 1 0",
                  write_en, write_reg, write_data, count, empty, full, in_ready, pend_hit);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pend_query = '0;
   endtask

   task automatic test_single_write();
      logic acc;
      hold = 1'b0;
      push(5'd5, 32'h0000_00AA, acc);
      idle();
      n_cmp++;
      if (write_en !== 1'b0) begin
         n_err++; $display("FAIL single_early: got write_en=%b, expected 0", write_en);
      end
      @(negedge clk);
      n_cmp++;
      if ({write_en, write_reg, write_data} !== {1'b1, 5'd5, 32'hAA}) begin
         n_err++;
         $display("FAIL single_write: got en=%b reg=%0d data=%h, expected 1 5 000000aa", write_en, write_reg, write_data);
      end
      @(negedge clk);
      n_cmp++;
      if (write_en !== 1'b0 || empty !== 1'b1) begin
         n_err++; $display("FAIL single_one_cycle: got write_en=%b empty=%b, expected 0 1", write_en, empty);
      end
   endtask

   task automatic test_fill_order();
      logic acc;
      hold = 1'b1;
      for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 'h11), acc);
      idle();
      n_cmp++;
      if ({full, in_ready, count} !== {1'b1, 1'b0, 3'd4}) begin
         n_err++; $display("FAIL fill_full: got full=%b rdy=%b cnt=%0d, expected 1 0 4", full, in_ready, count);
      end
      push(5'd9, 32'h55, acc);
      n_cmp++;
      if (acc !== 1'b0) begin
         n_err++; $display("FAIL fill_fifth_ready: got in_ready=%b, expected 0", acc);
      end
      idle();
      n_cmp++;
      if (count !== 3'd4) begin
         n_err++; $display("FAIL fill_fifth_count: got %0d, expected 4", count);
      end
      hold = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({write_en, write_reg, write_data} !== {1'b1, 5'(i), 32'(i * 'h11)}) begin
            n_err++;
            $display("FAIL fill_order_%0d: got en=%b reg=%0d data=%h, expected 1 %0d %h",
                     i, write_en, write_reg, write_data, i, i * 'h11);
         end
      end
      n_cmp++;
      if (empty !== 1'b1) begin
         n_err++; $display("FAIL fill_empty: got empty=%b, expected 1", empty);
      end
      wait_drain("fill");
   endtask

   task automatic test_r0_drop();
      logic acc;
      hold = 1'b0;
      push(5'd0, 32'hDEAD, acc);
      pend_query = 5'd0;
      idle();
      n_cmp++;
      if (count !== 3'd0 || pend_hit !== 1'b0) begin
         n_err++; $display("FAIL r0_count: got cnt=%0d hit=%b, expected 0 0", count, pend_hit);
      end
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if (write_en !== 1'b0) begin
            n_err++; $display("FAIL r0_write: got write_en=%b, expected 0", write_en);
         end
      end
   endtask

   task automatic test_forward();
      logic acc;
      hold = 1'b1;
      push(5'd7, 32'h1, acc);
      push(5'd7, 32'h2, acc);
      push(5'd6, 32'h66, acc);
      idle();
      pend_query = 5'd7; #1;
      n_cmp++;
      if ({pend_hit, pend_data} !== {1'b1, 32'h2}) begin
         n_err++; $display("FAIL fwd_youngest: got hit=%b data=%h, expected 1 00000002", pend_hit, pend_data);
      end
      pend_query = 5'd8; #1;
      n_cmp++;
      if ({pend_hit, pend_data} !== {1'b0, 32'h0}) begin
         n_err++; $display("FAIL fwd_miss: got hit=%b data=%h, expected 0 0", pend_hit, pend_data);
      end
      pend_query = 5'd0; #1;
      n_cmp++;
      if (pend_hit !== 1'b0) begin
         n_err++; $display("FAIL fwd_r0: got hit=%b, expected 0", pend_hit);
      end
      // Two pops: (7,2) sits in the output register, nothing for 7 queued.
      hold = 1'b0;
      @(negedge clk);
      @(negedge clk);
      hold = 1'b1;
      pend_query = 5'd7; #1;
      n_cmp++;
      if ({write_en, pend_hit, pend_data} !== {1'b1, 1'b1, 32'h2}) begin
         n_err++; $display("FAIL fwd_outreg: got en=%b hit=%b data=%h, expected 1 1 00000002", write_en, pend_hit, pend_data);
      end
      hold = 1'b0;
      pend_query = 5'd0;
      wait_drain("fwd");
   endtask

   task automatic test_back_to_back();
      logic acc;
      hold = 1'b1;
      push(5'd10, 32'hA000, acc);
      push(5'd11, 32'hA001, acc);
      for (int i = 0; i < 10; i++) begin
         push(5'(12 + i), 32'hB000 + 32'(i), acc);
         hold = 1'b0;
         n_cmp++;
         if (count !== 3'd2 || acc !== 1'b1) begin
            n_err++; $display("FAIL b2b_count_%0d: got cnt=%0d rdy=%b, expected 2 1", i, count, acc);
         end
      end
      idle();
      wait_drain("b2b");
   endtask

   task automatic test_reset_mid_drain();
      logic acc;
      hold = 1'b1;
      for (int i = 0; i < 4; i++) push(5'(20 + i), 32'hC000 + 32'(i), acc);
      idle();
      hold = 1'b0;
      @(negedge clk);
      #2;
      pend_query = 5'd22;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({write_en, write_reg, write_data, count, empty, full, in_ready, pend_hit} !==
          {1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL rst_mid_outputs: got en=%b reg=%0d data=%h cnt=%0d e=%b f=%b rdy=%b hit=%b, expected 0 0 0 0 1 0 1 0",
                  write_en, write_reg, write_data, count, empty, full, in_ready, pend_hit);
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pend_query = 5'd0;
      repeat (6) begin
         @(negedge clk);
         n_cmp++;
         if (write_en !== 1'b0 || empty !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_after: got write_en=%b empty=%b, expected 0 1", write_en, empty);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_fill_order();
      test_r0_drop();
      test_forward();
      test_back_to_back();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
